// File: rtl/mux2_arb_pkg.sv
// Shared types for the two-requester byte-path arbiter: FSM states and
// mux select encodings.
package mux2_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_A = 2'd1,
      GRANT_B = 2'd2
   } arb_state_e;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   // Owner chosen from IDLE; on a tie the requester not served last wins.
   function automatic arb_state_e arb_pick(input logic req_a, input logic req_b,
                                           input logic last_owner);
      arb_pick = IDLE;
      if (req_a && (!req_b || last_owner == SEL_B))
         arb_pick = GRANT_A;
      else if (req_b)
         arb_pick = GRANT_B;
   endfunction

endpackage

// File: rtl/mux2_byte_arbiter_mux2t1_8.sv
// 8-bit 2:1 byte mux feeding the arbiter's output register.
module MUX2T1_8 (
   input  logic       s,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] y
);

   assign y = s ? b : a;

endmodule

// File: rtl/mux2_byte_arbiter.sv
// Round-robin owner of a shared 8-bit byte path between requesters A and B,
// with burst grants, forced release after MAX_HOLD bytes, and a registered output.
module mux2_byte_arbiter
   import mux2_arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_a,
   input  logic       last_a,
   input  logic [7:0] data_a,
   input  logic       req_b,
   input  logic       last_b,
   input  logic [7:0] data_b,
   output logic       gnt_a,
   output logic       gnt_b,
   output logic       sel,
   output logic [7:0] o_data,
   output logic       o_valid
);

   localparam int              CW        = $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0]   HOLD_LAST = CW'(MAX_HOLD - 1);

   arb_state_e    r_state;
   arb_state_e    w_state_nxt;
   logic          r_last_owner;
   logic          r_sel;
   logic          r_gnt_a;
   logic          r_gnt_b;
   logic          r_valid;
   logic [7:0]    r_data;
   logic [CW-1:0] r_cnt;

   logic          w_req;
   logic          w_last;
   logic          w_xfer;
   logic          w_release;
   logic [7:0]    w_mux_data;

   MUX2T1_8 u_mux (
      .s (r_sel),
      .a (data_a),
      .b (data_b),
      .y (w_mux_data)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_req       = 1'b0;
      w_last      = 1'b0;
      w_xfer      = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         IDLE: w_state_nxt = arb_pick(req_a, req_b, r_last_owner);
         GRANT_A: begin
            w_req  = req_a;
            w_last = last_a;
         end
         GRANT_B: begin
            w_req  = req_b;
            w_last = last_b;
         end
         default: w_state_nxt = IDLE;
      endcase
      // The owner's own req qualifies both the transfer and its last flag.
      if (r_state == GRANT_A || r_state == GRANT_B) begin
         w_xfer    = w_req;
         w_release = !w_req || w_last || (r_cnt == HOLD_LAST);
         if (w_release)
            w_state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_last_owner <= SEL_B;
         r_sel        <= SEL_A;
         r_gnt_a      <= 1'b0;
         r_gnt_b      <= 1'b0;
         r_valid      <= 1'b0;
         r_data       <= 8'h00;
         r_cnt        <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt_a <= (w_state_nxt == GRANT_A);
         r_gnt_b <= (w_state_nxt == GRANT_B);
         // sel only moves when a new grant starts, so it is frozen in IDLE.
         if (w_state_nxt == GRANT_A)
            r_sel <= SEL_A;
         else if (w_state_nxt == GRANT_B)
            r_sel <= SEL_B;
         r_valid <= w_xfer;
         if (w_xfer)
            r_data <= w_mux_data;
         if (w_release) begin
            r_cnt        <= '0;
            r_last_owner <= (r_state == GRANT_B) ? SEL_B : SEL_A;
         end else if (w_xfer) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign gnt_a   = r_gnt_a;
   assign gnt_b   = r_gnt_b;
   assign sel     = r_sel;
   assign o_data  = r_data;
   assign o_valid = r_valid;

endmodule

// File: tb/tb_mux2_byte_arbiter.sv
// Scoreboard bench for mux2_byte_arbiter: directed bursts with hand-written
// expected bytes and grant order, plus a random invariant phase.
module tb_mux2_byte_arbiter;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } item_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_a = 1'b0, last_a = 1'b0, req_b = 1'b0, last_b = 1'b0;
   logic [7:0] data_a = 8'h00, data_b = 8'h00;
   logic       gnt_a, gnt_b, sel, o_valid;
   logic [7:0] o_data;

   item_t      qa[$];
   item_t      qb[$];
   logic [7:0] exp_q[$];
   logic       exp_gnt[$];

   int  n_vec = 0;
   int  n_fail = 0;
   int  n_valid = 0;
   int  n_xfer = 0;
   bit  rnd_mode = 1'b0;
   bit  xa = 1'b0, xb = 1'b0;
   logic pa = 1'b0, pb = 1'b0, psel = 1'b0;

   always #5 clk = ~clk;

   mux2_byte_arbiter #(.MAX_HOLD(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req_a  (req_a),
      .last_a (last_a),
      .data_a (data_a),
      .req_b  (req_b),
      .last_b (last_b),
      .data_b (data_b),
      .gnt_a  (gnt_a),
      .gnt_b  (gnt_b),
      .sel    (sel),
      .o_data (o_data),
      .o_valid(o_valid)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_vec++;
      n_fail++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (qa.size() == 0 && qb.size() == 0 && !gnt_a && !gnt_b && exp_q.size() == 0)
            return;
      end
      fail_now("idle_timeout");
   endtask

   // Producers: present queue heads, advance once a byte has been taken.
   initial forever begin
      @(posedge clk);
      #1;
      if (!rnd_mode) begin
         if (rst_n && xa && qa.size() > 0) void'(qa.pop_front());
         if (rst_n && xb && qb.size() > 0) void'(qb.pop_front());
         req_a  = qa.size() > 0;
         data_a = req_a ? qa[0].d : 8'h00;
         last_a = req_a ? qa[0].l : 1'b0;
         req_b  = qb.size() > 0;
         data_b = req_b ? qb[0].d : 8'h00;
         last_b = req_b ? qb[0].l : 1'b0;
      end
   end

   initial forever begin
      @(negedge clk);
      xa = rst_n && gnt_a && req_a;
      xb = rst_n && gnt_b && req_b;
   end

   // Monitor: byte scoreboard, grant order, and per-cycle invariants.
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (o_valid) begin
            n_valid++;
            if (exp_q.size() == 0) fail_now("unexpected_byte");
            else chk("o_data", o_data, exp_q.pop_front());
         end
         chk("mutex", gnt_a & gnt_b, 0);
         if (gnt_a | gnt_b) begin
            chk("sel_owner", sel, gnt_b);
            if (pa | pb) chk("sel_stable", sel, psel);
         end
         if ((gnt_a && !pa) || (gnt_b && !pb)) begin
            chk("idle_gap", pa | pb, 0);
            if (!rnd_mode) begin
               if (exp_gnt.size() == 0) fail_now("extra_grant");
               else chk("grant_order", gnt_b, exp_gnt.pop_front());
            end
         end
         if (gnt_a && req_a) begin
            n_xfer++;
            if (rnd_mode) exp_q.push_back(data_a);
         end
         if (gnt_b && req_b) begin
            n_xfer++;
            if (rnd_mode) exp_q.push_back(data_b);
         end
      end
      pa   = gnt_a;
      pb   = gnt_b;
      psel = sel;
   end

   initial begin
      #800000;
      $display("FAIL watchdog at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #12;
      chk("rst_gnt_a", gnt_a, 0);
      chk("rst_gnt_b", gnt_b, 0);
      chk("rst_sel", sel, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_data", o_data, 8'h00);
      #10 rst_n = 1'b1;

      // Single burst from A with latency checks
      @(negedge clk);
      qa.push_back('{8'h11, 1'b0});
      qa.push_back('{8'h22, 1'b0});
      qa.push_back('{8'h33, 1'b1});
      exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
      exp_gnt.push_back(1'b0);
      @(negedge clk);
      chk("gnt_lat_pre", gnt_a, 0);
      @(negedge clk);
      chk("gnt_lat", gnt_a, 1);
      chk("first_byte_lat", o_valid, 0);
      wait_idle();
      chk("a_done_gnt", gnt_a, 0);
      chk("a_done_sel", sel, 0);

      // Tie-break and alternation from a fresh reset
      @(posedge clk); #2 rst_n = 1'b0; #2 rst_n = 1'b1;
      @(negedge clk);
      qa.push_back('{8'hA1, 1'b0}); qa.push_back('{8'hA2, 1'b1});
      qa.push_back('{8'hA3, 1'b0}); qa.push_back('{8'hA4, 1'b1});
      qb.push_back('{8'hB1, 1'b0}); qb.push_back('{8'hB2, 1'b1});
      qb.push_back('{8'hB3, 1'b0}); qb.push_back('{8'hB4, 1'b1});
      exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
      exp_q.push_back(8'hB1); exp_q.push_back(8'hB2);
      exp_q.push_back(8'hA3); exp_q.push_back(8'hA4);
      exp_q.push_back(8'hB3); exp_q.push_back(8'hB4);
      exp_gnt.push_back(1'b0); exp_gnt.push_back(1'b1);
      exp_gnt.push_back(1'b0); exp_gnt.push_back(1'b1);
      wait_idle();

      // Forced release at MAX_HOLD=4: B0..B3, B4..B7, B8..B9
      for (int i = 0; i < 10; i++) begin
         qb.push_back('{8'hB0 + 8'(i), 1'b0});
         exp_q.push_back(8'hB0 + 8'(i));
      end
      exp_gnt.push_back(1'b1); exp_gnt.push_back(1'b1); exp_gnt.push_back(1'b1);
      wait_idle();

      // Request drop after two bytes; A becomes last owner so the tie goes to B
      qa.push_back('{8'hC1, 1'b0}); qa.push_back('{8'hC2, 1'b0});
      exp_q.push_back(8'hC1); exp_q.push_back(8'hC2);
      exp_gnt.push_back(1'b0);
      wait_idle();
      qa.push_back('{8'hD1, 1'b1});
      qb.push_back('{8'hE1, 1'b1});
      exp_q.push_back(8'hE1); exp_q.push_back(8'hD1);
      exp_gnt.push_back(1'b1); exp_gnt.push_back(1'b0);
      wait_idle();

      // Async reset in the middle of a B burst
      for (int i = 0; i < 4; i++) qb.push_back('{8'hF0 + 8'(i), (i == 3)});
      exp_gnt.push_back(1'b1);
      begin
         int k;
         for (k = 0; k < 20 && !gnt_b; k++) @(negedge clk);
         if (!gnt_b) fail_now("b_grant_timeout");
      end
      @(posedge clk); #2;
      chk("pre_rst_valid", o_valid, 1);
      chk("pre_rst_data", o_data, 8'hF0);
      chk("pre_rst_sel", sel, 1);
      rst_n = 1'b0;
      qa.delete(); qb.delete();
      #1;
      chk("arst_gnt_b", gnt_b, 0);
      chk("arst_sel", sel, 0);
      chk("arst_valid", o_valid, 0);
      chk("arst_data", o_data, 8'h00);
      @(posedge clk); #3 rst_n = 1'b1;
      @(negedge clk);
      qa.push_back('{8'h61, 1'b1});
      qb.push_back('{8'h71, 1'b1});
      exp_q.push_back(8'h61); exp_q.push_back(8'h71);
      exp_gnt.push_back(1'b0); exp_gnt.push_back(1'b1);
      wait_idle();

      // Random traffic: invariants plus byte/valid accounting
      @(negedge clk);
      n_valid = 0;
      n_xfer  = 0;
      rnd_mode = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         @(posedge clk); #1;
         req_a  = ($urandom_range(0, 3) != 0);
         last_a = ($urandom_range(0, 3) == 0);
         data_a = 8'($urandom);
         req_b  = ($urandom_range(0, 3) != 0);
         last_b = ($urandom_range(0, 3) == 0);
         data_b = 8'($urandom);
      end
      @(posedge clk); #1;
      req_a = 1'b0; req_b = 1'b0; last_a = 1'b0; last_b = 1'b0;
      repeat (4) @(negedge clk);
      chk("rnd_drained", exp_q.size(), 0);
      chk("rnd_valid_count", n_valid, n_xfer);
      rnd_mode = 1'b0;

      chk("grants_consumed", exp_gnt.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
